// File: rtl/mii_pkg.sv
// Shared definitions for the MII receive path: FSM states, preamble/SFD
// nibbles, CRC-32 constants and the broadcast address.
package mii_pkg;

  typedef enum logic [2:0] {
    ST_DROP = 3'd0,
    ST_IDLE = 3'd1,
    ST_PRE  = 3'd2,
    ST_DATA = 3'd3
  } rx_state_t;

  localparam logic [3:0]  PRE_NIB     = 4'h5;
  localparam logic [3:0]  SFD_NIB     = 4'hD;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [47:0] BCAST_ADDR  = '1;

  // Byte idx of a MAC address in wire order (idx 0 = bits [47:40]).
  function automatic logic [7:0] mac_byte(input logic [47:0] addr, input logic [2:0] idx);
    logic [47:0] sh;
    sh = addr << {idx, 3'b000};
    return sh[47:40];
  endfunction

endpackage

// File: rtl/mii_rx_crc32.sv
// Combinational CRC-32 (reflected) update for one MII nibble, LSB first.
module mii_rx_crc32
  import mii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  nibble,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int unsigned i = 0; i < 4; i++) begin
      if (crc_out[0] ^ nibble[i])
        crc_out = (crc_out >> 1) ^ CRC_POLY;
      else
        crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/mii_rx.sv
// MII receive front end: strips preamble/SFD, assembles bytes low nibble
// first, and flags bad frames at eof. FCS checking under MII_RX_FCS_CHECK_EN.
module mii_rx
  import mii_pkg::*;
#(
  parameter logic [47:0] P_MAC_ADDR  = 48'h3A52023E1800,
  parameter int unsigned P_MIN_FRAME = 64,
  parameter int unsigned P_MAX_FRAME = 1518
) (
  input  logic       rx_clk,
  input  logic       rx_rst_n,
  input  logic [3:0] rx_data,
  input  logic       rx_dv,
  input  logic       rx_er,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_err,
  output logic [2:0] rx_state_probe
);

  localparam logic [10:0] MIN_CNT = 11'(P_MIN_FRAME);
  localparam logic [10:0] MAX_CNT = 11'(P_MAX_FRAME);

  logic [3:0]  data_q;
  logic        dv_q;
  logic        er_q;

  rx_state_t   state;
  logic        phase;
  logic [3:0]  lo_nib;
  logic [7:0]  held;
  logic        have_held;
  logic        sent_first;
  logic [10:0] byte_cnt;
  logic        er_seen;
  logic        mac_ok;
  logic        bc_ok;

  logic [7:0]  new_byte;
  logic [10:0] cnt_inc;
  logic        fcs_bad;
  logic        frame_bad;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      data_q <= '0;
      dv_q   <= 1'b0;
      er_q   <= 1'b0;
    end else begin
      data_q <= rx_data;
      dv_q   <= rx_dv;
      er_q   <= rx_er;
    end
  end

`ifdef MII_RX_FCS_CHECK_EN
  logic [31:0] crc_q;
  logic [31:0] crc_nxt;

  mii_rx_crc32 u_crc (
    .crc_in  (crc_q),
    .nibble  (data_q),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n)
      crc_q <= CRC_INIT;
    else if (state == ST_PRE && dv_q && data_q == SFD_NIB)
      crc_q <= CRC_INIT;
    else if (state == ST_DATA && dv_q)
      crc_q <= crc_nxt;
  end

  assign fcs_bad = (crc_q != CRC_RESIDUE);
`else
  assign fcs_bad = 1'b0;
`endif

  assign new_byte  = {data_q, lo_nib};
  assign cnt_inc   = (byte_cnt == '1) ? byte_cnt : byte_cnt + 11'd1;
  // Evaluated at dv fall: the partial-nibble case shows up as phase=1.
  assign frame_bad = er_seen | phase | (byte_cnt < MIN_CNT) | ~(mac_ok | bc_ok) | fcs_bad;

  assign rx_state_probe = 3'(state);

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state       <= ST_DROP;
      phase       <= 1'b0;
      lo_nib      <= '0;
      held        <= '0;
      have_held   <= 1'b0;
      sent_first  <= 1'b0;
      byte_cnt    <= '0;
      er_seen     <= 1'b0;
      mac_ok      <= 1'b0;
      bc_ok       <= 1'b0;
      rx_byte     <= '0;
      rx_byte_vld <= 1'b0;
      rx_sof      <= 1'b0;
      rx_eof      <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      rx_byte_vld <= 1'b0;
      rx_sof      <= 1'b0;
      rx_eof      <= 1'b0;
      rx_err      <= 1'b0;

      case (state)
        ST_DROP: begin
          if (!dv_q) state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (dv_q) state <= (data_q == PRE_NIB) ? ST_PRE : ST_DROP;
        end

        ST_PRE: begin
          if (!dv_q) begin
            state <= ST_IDLE;
          end else if (data_q == SFD_NIB) begin
            state      <= ST_DATA;
            phase      <= 1'b0;
            have_held  <= 1'b0;
            sent_first <= 1'b0;
            byte_cnt   <= '0;
            er_seen    <= 1'b0;
            mac_ok     <= 1'b1;
            bc_ok      <= 1'b1;
          end else if (data_q != PRE_NIB) begin
            state <= ST_DROP;
          end
        end

        ST_DATA: begin
          if (!dv_q) begin
            state <= ST_IDLE;
            if (have_held) begin
              rx_byte     <= held;
              rx_byte_vld <= 1'b1;
              rx_sof      <= ~sent_first;
              rx_eof      <= 1'b1;
              rx_err      <= frame_bad;
            end
          end else begin
            if (er_q) er_seen <= 1'b1;
            if (!phase) begin
              lo_nib <= data_q;
              phase  <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (byte_cnt == MAX_CNT) begin
                // Overlength: the new byte is dropped, the held one closes the frame.
                rx_byte     <= held;
                rx_byte_vld <= 1'b1;
                rx_sof      <= ~sent_first;
                rx_eof      <= 1'b1;
                rx_err      <= 1'b1;
                state       <= ST_DROP;
              end else begin
                if (have_held) begin
                  rx_byte     <= held;
                  rx_byte_vld <= 1'b1;
                  rx_sof      <= ~sent_first;
                  sent_first  <= 1'b1;
                end
                held      <= new_byte;
                have_held <= 1'b1;
                byte_cnt  <= cnt_inc;
                if (byte_cnt < 11'd6) begin
                  mac_ok <= mac_ok & (new_byte == mac_byte(P_MAC_ADDR, byte_cnt[2:0]));
                  bc_ok  <= bc_ok & (new_byte == BCAST_ADDR[7:0]);
                end
              end
            end
          end
        end

        default: state <= ST_DROP;
      endcase
    end
  end

endmodule
